// File: rtl/ashi_regfile.sv
// rtl/ashi_regfile.sv - ASHI register file: control, command strobe, W1C status with irq, 64-bit counter.
// Optional ASHI_REGFILE_SNAPSHOT_EN: a CNT_LO read latches counter[63:32] for the next CNT_HI read.
module ashi_regfile #(
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] ASHI_WINDX,
  input  logic [31:0] ASHI_WDATA,
  input  logic        ASHI_WRITE,
  output logic        ASHI_WIDLE,
  output logic [1:0]  ASHI_WRESP,
  input  logic [31:0] ASHI_RINDX,
  input  logic        ASHI_READ,
  output logic        ASHI_RIDLE,
  output logic [31:0] ASHI_RDATA,
  output logic [1:0]  ASHI_RRESP,
  output logic [31:0] ctrl_out,
  output logic        start_pulse,
  input  logic [7:0]  event_in,
  output logic        irq
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_BUSY } w_state_t;
  typedef enum logic { R_IDLE, R_BUSY } r_state_t;

  w_state_t    r_wstate;
  r_state_t    r_rstate;
  logic [31:0] r_windx, r_wdata, r_rindx;
  logic        r_widle, r_ridle;
  logic [1:0]  r_wresp, r_rresp;
  logic [31:0] r_rdata;
  logic        r_start_pulse, r_irq;
  logic [31:0] r_ctrl, r_scratch;
  logic [7:0]  r_status, r_irq_mask;
  logic [63:0] r_cnt;

  logic        w_wr_err, w_wr_go, w_rd_err;
  logic [7:0]  w_status_clr;
  logic [31:0] w_rd_data, w_cnt_hi;

  // Indices 5..7 are read-only and everything from 8 up is unmapped.
  assign w_wr_err     = (r_windx > 32'd4);
  assign w_wr_go      = (r_wstate == W_BUSY) && !w_wr_err;
  assign w_status_clr = (w_wr_go && r_windx == 32'd2) ? r_wdata[7:0] : 8'h00;
  assign w_rd_err     = (r_rindx > 32'd7);

`ifdef ASHI_REGFILE_SNAPSHOT_EN
  logic [31:0] r_cnt_hi_shadow;

  always_ff @(posedge clk) begin
    if (!resetn)
      r_cnt_hi_shadow <= 32'h0;
    else if (r_rstate == R_BUSY && r_rindx == 32'd5)
      r_cnt_hi_shadow <= r_cnt[63:32];
  end

  assign w_cnt_hi = r_cnt_hi_shadow;
`else
  assign w_cnt_hi = r_cnt[63:32];
`endif

  always_comb begin
    w_rd_data = 32'h0;
    case (r_rindx)
      32'd0:   w_rd_data = r_ctrl;
      32'd2:   w_rd_data = {24'h0, r_status};
      32'd3:   w_rd_data = {24'h0, r_irq_mask};
      32'd4:   w_rd_data = r_scratch;
      32'd5:   w_rd_data = r_cnt[31:0];
      32'd6:   w_rd_data = w_cnt_hi;
      32'd7:   w_rd_data = VERSION;
      default: w_rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wstate      <= W_IDLE;
      r_windx       <= 32'h0;
      r_wdata       <= 32'h0;
      r_widle       <= 1'b1;
      r_wresp       <= RESP_OKAY;
      r_start_pulse <= 1'b0;
      r_ctrl        <= 32'h0;
      r_irq_mask    <= 8'h0;
      r_scratch     <= 32'h0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (ASHI_WRITE) begin
            r_windx       <= ASHI_WINDX;
            r_wdata       <= ASHI_WDATA;
            r_widle       <= 1'b0;
            r_start_pulse <= (ASHI_WINDX == 32'd1) && ASHI_WDATA[0];
            r_wstate      <= W_BUSY;
          end
        end
        W_BUSY: begin
          r_widle       <= 1'b1;
          r_wresp       <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
          r_start_pulse <= 1'b0;
          r_wstate      <= W_IDLE;
          if (w_wr_go) begin
            case (r_windx[2:0])
              3'd0:    r_ctrl     <= r_wdata;
              3'd3:    r_irq_mask <= r_wdata[7:0];
              3'd4:    r_scratch  <= r_wdata;
              default: ;
            endcase
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rstate <= R_IDLE;
      r_rindx  <= 32'h0;
      r_ridle  <= 1'b1;
      r_rdata  <= 32'h0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (ASHI_READ) begin
            r_rindx  <= ASHI_RINDX;
            r_ridle  <= 1'b0;
            r_rstate <= R_BUSY;
          end
        end
        R_BUSY: begin
          r_rdata  <= w_rd_err ? 32'h0 : w_rd_data;
          r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
          r_ridle  <= 1'b1;
          r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // New events take priority over a write-1-to-clear landing on the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_status <= 8'h0;
      r_irq    <= 1'b0;
      r_cnt    <= 64'h0;
    end else begin
      r_status <= (r_status & ~w_status_clr) | event_in;
      r_irq    <= |(r_status & r_irq_mask);
      r_cnt    <= r_cnt + 64'd1;
    end
  end

  assign ASHI_WIDLE  = r_widle;
  assign ASHI_WRESP  = r_wresp;
  assign ASHI_RIDLE  = r_ridle;
  assign ASHI_RDATA  = r_rdata;
  assign ASHI_RRESP  = r_rresp;
  assign ctrl_out    = r_ctrl;
  assign start_pulse = r_start_pulse;
  assign irq         = r_irq;

endmodule

// File: tb/tb_ashi_regfile.sv
// tb/tb_ashi_regfile.sv - directed self-checking bench for ashi_regfile.
module tb_ashi_regfile;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] ASHI_WINDX, ASHI_WDATA, ASHI_RINDX;
  logic        ASHI_WRITE, ASHI_READ;
  logic        ASHI_WIDLE, ASHI_RIDLE;
  logic [1:0]  ASHI_WRESP, ASHI_RRESP;
  logic [31:0] ASHI_RDATA, ctrl_out;
  logic        start_pulse, irq;
  logic [7:0]  event_in;

  int n_total = 0;
  int n_bad   = 0;

  logic [1:0]  resp;
  logic [31:0] rd;
  logic        sp;

  ashi_regfile dut (
    .clk(clk), .resetn(resetn),
    .ASHI_WINDX(ASHI_WINDX), .ASHI_WDATA(ASHI_WDATA), .ASHI_WRITE(ASHI_WRITE),
    .ASHI_WIDLE(ASHI_WIDLE), .ASHI_WRESP(ASHI_WRESP),
    .ASHI_RINDX(ASHI_RINDX), .ASHI_READ(ASHI_READ), .ASHI_RIDLE(ASHI_RIDLE),
    .ASHI_RDATA(ASHI_RDATA), .ASHI_RRESP(ASHI_RRESP),
    .ctrl_out(ctrl_out), .start_pulse(start_pulse), .event_in(event_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic ashi_wr(input logic [31:0] idx, input logic [31:0] data,
                         output logic [1:0] r, output logic p);
    @(negedge clk);
    ASHI_WINDX = idx; ASHI_WDATA = data; ASHI_WRITE = 1'b1;
    @(negedge clk);
    ASHI_WRITE = 1'b0;
    chk("widle_low", ASHI_WIDLE, 1'b0);
    p = start_pulse;
    @(negedge clk);
    chk("widle_back", ASHI_WIDLE, 1'b1);
    chk("pulse_gone", start_pulse, 1'b0);
    r = ASHI_WRESP;
  endtask

  task automatic ashi_rd(input logic [31:0] idx, output logic [31:0] d, output logic [1:0] r);
    @(negedge clk);
    ASHI_RINDX = idx; ASHI_READ = 1'b1;
    @(negedge clk);
    ASHI_READ = 1'b0;
    chk("ridle_low", ASHI_RIDLE, 1'b0);
    @(negedge clk);
    chk("ridle_back", ASHI_RIDLE, 1'b1);
    d = ASHI_RDATA;
    r = ASHI_RRESP;
  endtask

  initial begin
    resetn = 1'b0;
    ASHI_WINDX = '0; ASHI_WDATA = '0; ASHI_WRITE = 1'b0;
    ASHI_RINDX = '0; ASHI_READ = 1'b0; event_in = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_widle", ASHI_WIDLE, 1'b1);
    chk("rst_ridle", ASHI_RIDLE, 1'b1);
    chk("rst_resp", {ASHI_WRESP, ASHI_RRESP}, 4'b0);
    chk("rst_rdata", ASHI_RDATA, 32'h0);
    chk("rst_ctrl", ctrl_out, 32'h0);
    chk("rst_irq_sp", {irq, start_pulse}, 2'b00);
    resetn = 1'b1;

    // scratch round trip, and read data holds while idle
    ashi_wr(32'd4, 32'hA5A5_1234, resp, sp);
    chk("scr_wresp", resp, 2'b00);
    ashi_rd(32'd4, rd, resp);
    chk("scr_rdata", rd, 32'hA5A5_1234);
    chk("scr_rresp", resp, 2'b00);
    repeat (3) @(negedge clk);
    chk("rdata_hold", ASHI_RDATA, 32'hA5A5_1234);

    // error accesses leave state untouched
    ashi_wr(32'd0, 32'h0000_1111, resp, sp);
    chk("ctrl_out", ctrl_out, 32'h0000_1111);
    ashi_wr(32'd9, 32'hDEAD_BEEF, resp, sp);
    chk("w9_resp", resp, 2'b10);
    ashi_rd(32'd12, rd, resp);
    chk("r12_data", rd, 32'h0);
    chk("r12_resp", resp, 2'b10);
    ashi_wr(32'd7, 32'hDEAD_BEEF, resp, sp);
    chk("w7_resp", resp, 2'b10);
    ashi_wr(32'd5, 32'hDEAD_BEEF, resp, sp);
    chk("w5_resp", resp, 2'b10);
    ashi_rd(32'd7, rd, resp);
    chk("version", rd, 32'h0001_0000);
    ashi_rd(32'd0, rd, resp);
    chk("ctrl_kept", rd, 32'h0000_1111);
    ashi_rd(32'd4, rd, resp);
    chk("scr_kept", rd, 32'hA5A5_1234);

    // simultaneous write and read of scratch: read sees the old value
    @(negedge clk);
    ASHI_WINDX = 32'd4; ASHI_WDATA = 32'h0BAD_F00D; ASHI_WRITE = 1'b1;
    ASHI_RINDX = 32'd4; ASHI_READ = 1'b1;
    @(negedge clk);
    ASHI_WRITE = 1'b0; ASHI_READ = 1'b0;
    @(negedge clk);
    chk("both_idle", {ASHI_WIDLE, ASHI_RIDLE}, 2'b11);
    chk("rw_old", ASHI_RDATA, 32'hA5A5_1234);
    ashi_rd(32'd4, rd, resp);
    chk("rw_new", rd, 32'h0BAD_F00D);

    // status / irq
    ashi_wr(32'd3, 32'h0000_0004, resp, sp);
    @(negedge clk); event_in = 8'h05;
    @(negedge clk); event_in = 8'h00;
    @(negedge clk);
    chk("irq_set", irq, 1'b1);
    ashi_rd(32'd2, rd, resp);
    chk("status5", rd, 32'h05);
    ashi_wr(32'd2, 32'h0000_0004, resp, sp);
    ashi_rd(32'd2, rd, resp);
    chk("status1", rd, 32'h01);
    chk("irq_clr", irq, 1'b0);
    @(negedge clk);
    ASHI_WINDX = 32'd2; ASHI_WDATA = 32'h1; ASHI_WRITE = 1'b1;
    @(negedge clk);
    ASHI_WRITE = 1'b0; event_in = 8'h01;
    @(negedge clk);
    event_in = 8'h00;
    ashi_rd(32'd2, rd, resp);
    chk("set_wins", rd, 32'h01);

    // command strobe
    ashi_wr(32'd1, 32'h1, resp, sp);
    chk("cmd_pulse", sp, 1'b1);
    ashi_wr(32'd1, 32'h0, resp, sp);
    chk("cmd_nopulse", sp, 1'b0);
    ashi_rd(32'd1, rd, resp);
    chk("cmd_rd0", {resp, rd}, 34'h0);

    // counter high-word behaviour across a low-word wrap
    @(negedge clk);
    force dut.r_cnt = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.r_cnt;
    ASHI_RINDX = 32'd5; ASHI_READ = 1'b1;
    @(negedge clk);
    ASHI_READ = 1'b0;
    @(negedge clk);
    chk("cnt_lo", ASHI_RDATA, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    ashi_rd(32'd6, rd, resp);
`ifdef ASHI_REGFILE_SNAPSHOT_EN
    chk("cnt_hi", rd, 32'h0);
`else
    chk("cnt_hi", rd, 32'h1);
`endif

    // reset during W_BUSY aborts the CTRL write
    @(negedge clk);
    ASHI_WINDX = 32'd0; ASHI_WDATA = 32'hFF; ASHI_WRITE = 1'b1;
    @(negedge clk);
    ASHI_WRITE = 1'b0; resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_ctrl", ctrl_out, 32'h0);
    chk("abort_widle", ASHI_WIDLE, 1'b1);
    @(negedge clk);
    chk("abort_ctrl2", ctrl_out, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ashi_regfile.md
ASHI_REGFILE -- requirements
Module: ashi_regfile

Interface
REQ-001 SHALL have parameter VERSION, default 32'h0001_0000, constant value returned by register 7.
REQ-002 SHALL have ports: clk input 1 (clock); resetn input 1 (reset resetn, synchronous, active-low; clock clk).
REQ-003 SHALL have ASHI write-side ports: ASHI_WINDX in 32 (register index); ASHI_WDATA in 32; ASHI_WRITE in 1 (write strobe); ASHI_WIDLE out 1; ASHI_WRESP out 2.
REQ-004 SHALL have ASHI read-side ports: ASHI_RINDX in 32; ASHI_READ in 1 (read strobe); ASHI_RIDLE out 1; ASHI_RDATA out 32; ASHI_RRESP out 2.
REQ-005 SHALL have user ports: ctrl_out out 32 (CTRL register); start_pulse out 1 (command strobe); event_in in 8 (level events); irq out 1 (interrupt).

Function
REQ-006 Register map SHALL be: 0 CTRL RW; 1 CMD WO (reads 0); 2 STATUS[7:0] W1C; 3 IRQ_MASK[7:0] RW; 4 SCRATCH RW; 5 CNT_LO RO; 6 CNT_HI RO; 7 VERSION RO; unused bits read 0.
REQ-007 Write FSM SHALL have states W_IDLE, W_BUSY; in W_IDLE with ASHI_WRITE=1 it SHALL sample WINDX/WDATA, drop ASHI_WIDLE next cycle, enter W_BUSY.
REQ-008 In W_BUSY the update SHALL be applied, ASHI_WRESP set, ASHI_WIDLE raised, return to W_IDLE: WIDLE low exactly one cycle per write.
REQ-009 Read FSM SHALL have states R_IDLE, R_BUSY; ASHI_READ in R_IDLE SHALL drop ASHI_RIDLE next cycle; in R_BUSY ASHI_RDATA/ASHI_RRESP SHALL be registered and RIDLE raised, one cycle low per read.
REQ-010 ASHI_RDATA/ASHI_RRESP SHALL hold stable while RIDLE=1 until the next read completes.
REQ-011 Write/read FSMs SHALL be independent; simultaneous read and write SHALL both complete in two cycles; read SHALL return pre-write value when same register updated in the same cycle.
REQ-012 Responses: OKAY 2'b00 for valid access; SLVERR 2'b10 for index >= 8, or write to index 5, 6, 7; erroring writes SHALL change no state; erroring reads return RDATA 0.
REQ-013 Write to CMD with WDATA[0]=1 SHALL assert start_pulse for exactly one clk, in the W_BUSY cycle; WDATA[0]=0 produces no pulse.
REQ-014 STATUS[i] SHALL set on any clk with event_in[i]=1; write-1 to STATUS[i] clears it; set SHALL win over simultaneous clear.
REQ-015 irq SHALL be registered: irq = |(STATUS & IRQ_MASK), one cycle after the contributing state.
REQ-016 64-bit counter SHALL increment every clk from 0, wrapping 2^64-1 -> 0; CNT_LO returns bits [31:0], CNT_HI bits [63:32].
REQ-017 ctrl_out SHALL equal CTRL register continuously.
REQ-018 ASHI_READ or ASHI_WRITE asserted while corresponding FSM busy SHALL be ignored.

Reset
REQ-019 On resetn=0 at clk edge: both FSMs idle; ASHI_WIDLE=1, ASHI_RIDLE=1; WRESP=RRESP=0; RDATA=0; CTRL, STATUS, IRQ_MASK, SCRATCH, counter=0; start_pulse=0; irq=0.
REQ-020 Reset mid-transaction SHALL abort it, apply no pending write, and drop any pending start_pulse.

Configuration
REQ-021 Macro ASHI_REGFILE_SNAPSHOT_EN: when defined, a CNT_LO read SHALL capture counter[63:32] into a shadow (same clk as CNT_LO read data), and CNT_HI reads SHALL return the shadow (reset 0).
REQ-022 When undefined, CNT_HI SHALL return live counter[63:32] and no shadow register SHALL exist.

Verification
REQ-023 Write 0xA5A5_1234 to idx 4, read idx 4 -> WIDLE/RIDLE each low exactly 1 cycle, RDATA 0xA5A5_1234, RRESP 00.
REQ-024 Write idx 9, read idx 12, write idx 7 -> RESP 2'b10, RDATA 0, no register changed.
REQ-025 Pulse event_in=8'h05 one cycle, IRQ_MASK=0x04 -> STATUS=0x05, irq=1; write 0x04 to idx 2 -> STATUS=0x01, irq=0; write 0x01 while event_in[0]=1 -> STATUS[0] stays 1.
REQ-026 Write 0x1 to idx 1 -> start_pulse high exactly 1 clk; write 0x0 -> none; read idx 1 -> 0.
REQ-027 Force counter to 0x0000_0000_FFFF_FFFE, read CNT_LO then CNT_HI 3 clks later -> with SNAPSHOT_EN: HI=0; without: HI=1.
REQ-028 Assert resetn=0 during W_BUSY of CTRL write 0xFF -> ctrl_out=0, WIDLE=1 after reset.
